// File: rtl/conv_out_serializer.sv
// conv_out_serializer: captures a conv result frame in one cycle and streams
// it in raster order with per-word ReLU/shift/saturate requantization.
module conv_out_serializer #(
  parameter int WORD_LENGTH        = 8,
  parameter int DOUBLE_WORD_LENGTH = 16,
  parameter int OUTPUT_SIZE        = 32,
  parameter int SHIFT              = 4,
  parameter int RELU               = 1
) (
  input  logic                                                      clk,
  input  logic                                                      rst_n,
  input  logic                                                      in_valid,
  input  logic [DOUBLE_WORD_LENGTH*OUTPUT_SIZE*OUTPUT_SIZE-1:0]     data_in,
  input  logic                                                      out_ready,
  output logic                                                      out_valid,
  output logic [WORD_LENGTH-1:0]                                    data_out,
  output logic [DOUBLE_WORD_LENGTH-1:0]                             raw_out,
  output logic [5:0]                                                row_idx,
  output logic [5:0]                                                col_idx,
  output logic                                                      row_last,
  output logic                                                      frame_last,
  output logic                                                      busy,
  output logic [7:0]                                                drop_cnt
);
  localparam int N  = OUTPUT_SIZE * OUTPUT_SIZE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic signed [DOUBLE_WORD_LENGTH-1:0] U_MAX = DOUBLE_WORD_LENGTH'((1 << WORD_LENGTH) - 1);
  localparam logic signed [DOUBLE_WORD_LENGTH-1:0] S_MAX = DOUBLE_WORD_LENGTH'((1 << (WORD_LENGTH - 1)) - 1);
  localparam logic signed [DOUBLE_WORD_LENGTH-1:0] S_MIN = ~S_MAX;
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state;
  logic [DOUBLE_WORD_LENGTH*N-1:0] frame;
  logic [KW-1:0] k;
  logic in_q, offer, xfer, fin, cap;
  logic signed [DOUBLE_WORD_LENGTH-1:0] v, t;
  assign offer      = in_valid & ~in_q;
  assign xfer       = out_valid & out_ready;
  assign fin        = xfer & frame_last;
  assign cap        = offer & (state == IDLE | fin);
  assign row_last   = col_idx == 6'(OUTPUT_SIZE - 1);
  assign frame_last = k == KW'(N - 1);
  assign raw_out    = busy ? frame[DOUBLE_WORD_LENGTH*k +: DOUBLE_WORD_LENGTH] : '0;
  assign v          = raw_out;
  assign t          = v >>> SHIFT;
  assign data_out   = (RELU != 0) ? (v < 0 ? '0 : t > U_MAX ? U_MAX[WORD_LENGTH-1:0] : t[WORD_LENGTH-1:0])
                                  : (t > S_MAX ? S_MAX[WORD_LENGTH-1:0] : t < S_MIN ? S_MIN[WORD_LENGTH-1:0] : t[WORD_LENGTH-1:0]);
  // The frame buffer is deliberately left out of reset
  always_ff @(posedge clk)
    if (cap) frame <= data_in;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      row_idx   <= '0;
      col_idx   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      drop_cnt  <= '0;
      in_q      <= 1'b0;
    end else begin
      in_q <= in_valid;
      if (cap) begin
        state     <= STREAM;
        k         <= '0;
        row_idx   <= '0;
        col_idx   <= '0;
        out_valid <= 1'b1;
        busy      <= 1'b1;
      end else if (fin) begin
        state     <= IDLE;
        k         <= '0;
        row_idx   <= '0;
        col_idx   <= '0;
        out_valid <= 1'b0;
        busy      <= 1'b0;
      end else if (xfer) begin
        k       <= k + 1'b1;
        col_idx <= row_last ? '0 : col_idx + 1'b1;
        row_idx <= row_last ? row_idx + 1'b1 : row_idx;
      end
      if (offer && state == STREAM && !fin && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
endmodule

// File: tb/tb_conv_out_serializer.sv
// tb_conv_out_serializer: three instances (SHIFT/RELU = 0/1, 4/1, 4/0) share
// stimulus; a queue of expected words is checked on every transfer.
module tb_conv_out_serializer;
  localparam int WL = 8, DW = 16, OS = 32, N = OS * OS;
  typedef struct {logic [DW-1:0] w; int k;} exp_t;
  logic clk = 0, rst_n = 1, in_valid = 0, out_ready = 0;
  logic [DW*N-1:0] din = '0;
  logic ov[3], rl[3], fl[3], bz[3];
  logic [WL-1:0] d[3];
  logic [DW-1:0] raw[3];
  logic [5:0] row[3], col[3];
  logic [7:0] dc[3];
  int sh_of[3] = '{0, 4, 4};
  bit relu_of[3] = '{1, 1, 0};
  logic [DW-1:0] tab[4] = '{16'h7FFF, 16'h0100, 16'hFFF0, 16'h0017};
  exp_t q[$];
  int vecs = 0, miss = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    conv_out_serializer #(.WORD_LENGTH(WL), .DOUBLE_WORD_LENGTH(DW), .OUTPUT_SIZE(OS),
                          .SHIFT(g == 0 ? 0 : 4), .RELU(g == 2 ? 0 : 1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(din), .out_ready(out_ready),
      .out_valid(ov[g]), .data_out(d[g]), .raw_out(raw[g]), .row_idx(row[g]), .col_idx(col[g]),
      .row_last(rl[g]), .frame_last(fl[g]), .busy(bz[g]), .drop_cnt(dc[g]));
  end

  function automatic logic [WL-1:0] rq(input logic [DW-1:0] w, input int sh, input bit relu);
    int v, t;
    v = int'($signed(w));
    t = v >>> sh;
    if (relu) return v < 0 ? 8'd0 : t > 255 ? 8'd255 : 8'(t);
    return t > 127 ? 8'd127 : t < -128 ? 8'h80 : 8'(t);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int mode);
    for (int k = 0; k < N; k++)
      din[DW*k +: DW] = mode == 0 ? 16'(k) : mode == 1 ? tab[k % 4] : 16'($urandom);
  endtask

  task automatic push_frame();
    for (int k = 0; k < N; k++) q.push_back('{din[DW*k +: DW], k});
  endtask

  task automatic offer();
    in_valid = 1;
    push_frame();
    cyc();
    in_valid = 0;
    chk("capture_valid", 32'(ov[0]), 1);
    chk("capture_busy", 32'(bz[0]), 1);
  endtask

  task automatic check_beat(input exp_t e);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("raw%0d k=%0d", g, e.k), 32'(raw[g]), 32'(e.w));
      chk($sformatf("data%0d k=%0d", g, e.k), 32'(d[g]), 32'(rq(e.w, sh_of[g], relu_of[g])));
    end
    chk($sformatf("row k=%0d", e.k), 32'(row[0]), 32'(e.k / OS));
    chk($sformatf("col k=%0d", e.k), 32'(col[0]), 32'(e.k % OS));
    chk($sformatf("row_last k=%0d", e.k), 32'(rl[0]), 32'(e.k % OS == OS - 1));
    chk($sformatf("frame_last k=%0d", e.k), 32'(fl[0]), 32'(e.k == N - 1));
  endtask

  task automatic drain(input int beats, input bit rnd, input int offer_at, input bit push);
    int n = 0, cycles = 0;
    bit stalled = 0, offered = 0;
    logic [DW-1:0] sraw;
    logic [WL-1:0] sd;
    logic [5:0] srow, scol;
    while (n < beats && cycles < 20000) begin
      if (stalled) begin
        chk("stall_raw", 32'(raw[0]), 32'(sraw));
        chk("stall_data", 32'(d[1]), 32'(sd));
        chk("stall_row", 32'(row[0]), 32'(srow));
        chk("stall_col", 32'(col[0]), 32'(scol));
        stalled = 0;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = (n == offer_at) && !offered;
      if (in_valid) begin
        offered = 1;
        if (push) push_frame();
      end
      if (ov[0] && out_ready) begin
        chk("queue_nonempty", 32'(q.size() != 0), 1);
        if (q.size() != 0) check_beat(q.pop_front());
        n++;
      end else if (ov[0]) begin
        stalled = 1;
        sraw = raw[0]; sd = d[1]; srow = row[0]; scol = col[0];
      end
      cyc();
      cycles++;
    end
    in_valid = 0;
    out_ready = 0;
    chk("beats_done", 32'(n), 32'(beats));
  endtask

  initial begin
    #2 rst_n = 0;
    cyc();
    cyc();
    for (int g = 0; g < 3; g++) begin
      chk("rst_valid", 32'(ov[g]), 0);
      chk("rst_busy", 32'(bz[g]), 0);
      chk("rst_drop", 32'(dc[g]), 0);
      chk("rst_raw", 32'(raw[g]), 0);
      chk("rst_data", 32'(d[g]), 0);
      chk("rst_row", 32'(row[g]), 0);
      chk("rst_col", 32'(col[g]), 0);
    end
    rst_n = 1;
    cyc();
    // basic ramp frame, full throughput
    load(0);
    offer();
    drain(N, 0, -1, 0);
    chk("basic_end_valid", 32'(ov[0]), 0);
    chk("basic_end_busy", 32'(bz[0]), 0);
    // requant table words under random backpressure
    load(1);
    offer();
    drain(N, 1, -1, 0);
    chk("rq_end_valid", 32'(ov[0]), 0);
    // single drop at beat 100; din changes so a buffer overwrite shows
    load(2);
    offer();
    load(0);
    drain(N, 0, 100, 0);
    chk("drop_one", 32'(dc[0]), 1);
    chk("drop_end_valid", 32'(ov[0]), 0);
    // 300 offers while stalled saturate the drop counter
    load(2);
    offer();
    load(0);
    for (int i = 0; i < 300; i++) begin
      in_valid = 1;
      cyc();
      in_valid = 0;
      cyc();
    end
    for (int g = 0; g < 3; g++) chk("drop_sat", 32'(dc[g]), 255);
    chk("drop_sat_valid", 32'(ov[0]), 1);
    drain(N, 1, -1, 0);
    // back-to-back: offer lands on the final transfer
    load(2);
    offer();
    load(0);
    drain(N, 0, N - 1, 1);
    chk("b2b_valid", 32'(ov[0]), 1);
    chk("b2b_raw", 32'(raw[0]), 0);
    chk("b2b_row", 32'(row[0]), 0);
    chk("b2b_col", 32'(col[0]), 0);
    drain(N, 0, -1, 0);
    chk("b2b_end_valid", 32'(ov[0]), 0);
    chk("b2b_drop", 32'(dc[0]), 255);
    // reset mid-frame aborts at once
    load(2);
    offer();
    drain(500, 0, -1, 0);
    #2 rst_n = 0;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("mid_rst_valid", 32'(ov[g]), 0);
      chk("mid_rst_busy", 32'(bz[g]), 0);
      chk("mid_rst_drop", 32'(dc[g]), 0);
      chk("mid_rst_raw", 32'(raw[g]), 0);
    end
    q.delete();
    cyc();
    rst_n = 1;
    cyc();
    load(0);
    offer();
    drain(N, 0, -1, 0);
    chk("post_rst_end_valid", 32'(ov[0]), 0);
    chk("post_rst_drop", 32'(dc[0]), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
